// File: rtl/rename_pkg.sv
// Shared rename constants used by the rename file and its commit queue.
// Both blocks are instantiated from these so name widths always agree.
package rename_pkg;

  localparam int NAME_WIDTH = 1;
  localparam int PHYS_REGS  = 1 << NAME_WIDTH;
  localparam int CQ_DEPTH   = 4;
  localparam int CQ_PTR_W   = $clog2(CQ_DEPTH);

endpackage

// File: rtl/rename_commit_queue.sv
// In-order retirement queue for allocated physical names.
// Retires the oldest completed entry by driving the rename file free port.
module rename_commit_queue
  import rename_pkg::*;
#(
  parameter int name_width = NAME_WIDTH,
  parameter int depth      = CQ_DEPTH,
  parameter int ptr_width  = $clog2(depth)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [name_width-1:0] ENQ_NAME,
  input  logic                  ENQ_E,
  output logic                  ENQ_READY,
  input  logic [name_width-1:0] DONE_NAME_1,
  input  logic                  DONE_E_1,
  input  logic [name_width-1:0] DONE_NAME_2,
  input  logic                  DONE_E_2,
  input  logic                  COMMIT_E,
  output logic                  COMMIT_READY,
  output logic [name_width-1:0] HEAD_NAME,
  output logic [name_width-1:0] NAME_F,
  output logic                  FE,
  output logic [ptr_width:0]    COUNT
);

  localparam logic [ptr_width:0] FULL_CNT = (ptr_width+1)'(depth);
  localparam logic [ptr_width-1:0] PTR_ONE = ptr_width'(1);

  logic [name_width-1:0] ent_name [depth];
  logic [depth-1:0]      ent_done;
  logic [depth-1:0]      ent_valid;

  logic [ptr_width-1:0]  head;
  logic [ptr_width-1:0]  tail;
  logic [ptr_width:0]    cnt;

  logic                  enq_fire;
  logic                  commit_fire;
  logic                  enq_hit;
  logic [depth-1:0]      done_hit;
  logic [ptr_width:0]    cnt_n;

  assign ENQ_READY    = (cnt != FULL_CNT);
  assign COMMIT_READY = (cnt != '0) && ent_done[head];
  assign HEAD_NAME    = (cnt != '0) ? ent_name[head] : '0;
  assign NAME_F       = HEAD_NAME;
  assign FE           = COMMIT_E && COMMIT_READY;
  assign COUNT        = cnt;

  assign enq_fire    = ENQ_E && ENQ_READY;
  assign commit_fire = FE;

  // Writeback racing its own allocate still marks the new entry done.
  assign enq_hit = (DONE_E_1 && (DONE_NAME_1 == ENQ_NAME))
                || (DONE_E_2 && (DONE_NAME_2 == ENQ_NAME));

  always_comb begin
    done_hit = '0;
    for (int i = 0; i < depth; i++) begin
      done_hit[i] = ent_valid[i]
        && ((DONE_E_1 && (DONE_NAME_1 == ent_name[i]))
         || (DONE_E_2 && (DONE_NAME_2 == ent_name[i])));
    end
  end

  always_comb begin
    cnt_n = cnt;
    if (enq_fire && !commit_fire)
      cnt_n = cnt + (ptr_width+1)'(1);
    else if (!enq_fire && commit_fire)
      cnt_n = cnt - (ptr_width+1)'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      cnt <= cnt_n;
      if (enq_fire)
        tail <= tail + PTR_ONE;
      if (commit_fire)
        head <= head + PTR_ONE;
    end
  end

  // Enqueue and retire never target the same slot: that needs full or empty.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ent_done  <= '0;
      ent_valid <= '0;
      for (int i = 0; i < depth; i++)
        ent_name[i] <= '0;
    end else begin
      for (int i = 0; i < depth; i++) begin
        if (done_hit[i])
          ent_done[i] <= 1'b1;
        if (enq_fire && (tail == ptr_width'(i))) begin
          ent_name[i]  <= ENQ_NAME;
          ent_done[i]  <= enq_hit;
          ent_valid[i] <= 1'b1;
        end
        if (commit_fire && (head == ptr_width'(i))) begin
          ent_done[i]  <= 1'b0;
          ent_valid[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rename_commit_queue.sv
// Directed bench for rename_commit_queue with hand-computed expectations.
// Names are widened to 4 bits so the directed vectors fit.
module tb_rename_commit_queue;

  localparam int NW = 4;
  localparam int DP = 4;
  localparam int PW = 2;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [NW-1:0] ENQ_NAME = '0;
  logic          ENQ_E = 1'b0;
  logic          ENQ_READY;
  logic [NW-1:0] DONE_NAME_1 = '0;
  logic          DONE_E_1 = 1'b0;
  logic [NW-1:0] DONE_NAME_2 = '0;
  logic          DONE_E_2 = 1'b0;
  logic          COMMIT_E = 1'b0;
  logic          COMMIT_READY;
  logic [NW-1:0] HEAD_NAME;
  logic [NW-1:0] NAME_F;
  logic          FE;
  logic [PW:0]   COUNT;

  int n_chk = 0;
  int n_err = 0;

  rename_commit_queue #(
    .name_width(NW),
    .depth(DP),
    .ptr_width(PW)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .ENQ_NAME(ENQ_NAME),
    .ENQ_E(ENQ_E),
    .ENQ_READY(ENQ_READY),
    .DONE_NAME_1(DONE_NAME_1),
    .DONE_E_1(DONE_E_1),
    .DONE_NAME_2(DONE_NAME_2),
    .DONE_E_2(DONE_E_2),
    .COMMIT_E(COMMIT_E),
    .COMMIT_READY(COMMIT_READY),
    .HEAD_NAME(HEAD_NAME),
    .NAME_F(NAME_F),
    .FE(FE),
    .COUNT(COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_in();
    ENQ_E    = 1'b0;
    DONE_E_1 = 1'b0;
    DONE_E_2 = 1'b0;
    COMMIT_E = 1'b0;
  endtask

  task automatic enq(input logic [NW-1:0] n);
    ENQ_E    = 1'b1;
    ENQ_NAME = n;
    step();
    ENQ_E    = 1'b0;
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_enq_ready", 32'(ENQ_READY), 1);
    chk("rst_commit_ready", 32'(COMMIT_READY), 0);
    chk("rst_fe", 32'(FE), 0);
    chk("rst_count", 32'(COUNT), 0);
    chk("rst_name_f", 32'(NAME_F), 0);
    RST = 1'b0;
    step();
    settle();
    chk("idle_enq_ready", 32'(ENQ_READY), 1);
    chk("idle_count", 32'(COUNT), 0);

    // in-order retirement blocked by an incomplete head
    enq(5);
    enq(6);
    enq(7);
    settle();
    chk("q3_count", 32'(COUNT), 3);
    chk("q3_head", 32'(HEAD_NAME), 5);
    DONE_E_1 = 1'b1;
    DONE_NAME_1 = 6;
    COMMIT_E = 1'b1;
    settle();
    chk("head5_busy_fe", 32'(FE), 0);
    step();
    DONE_E_1 = 1'b0;
    settle();
    chk("head5_still_busy", 32'(COMMIT_READY), 0);
    DONE_E_1 = 1'b1;
    DONE_NAME_1 = 5;
    settle();
    chk("no_done_bypass", 32'(FE), 0);
    step();
    DONE_E_1 = 1'b0;
    settle();
    chk("ret5_fe", 32'(FE), 1);
    chk("ret5_name", 32'(NAME_F), 5);
    step();
    settle();
    chk("ret6_fe", 32'(FE), 1);
    chk("ret6_name", 32'(NAME_F), 6);
    step();
    settle();
    chk("head7_ready", 32'(COMMIT_READY), 0);
    chk("head7_name", 32'(HEAD_NAME), 7);
    chk("head7_count", 32'(COUNT), 1);
    COMMIT_E = 1'b0;

    // full queue and ignored enqueue
    enq(1);
    enq(2);
    enq(4);
    settle();
    chk("full_enq_ready", 32'(ENQ_READY), 0);
    chk("full_count", 32'(COUNT), 4);
    enq(9);
    settle();
    chk("full_ignore_count", 32'(COUNT), 4);
    DONE_E_1 = 1'b1;
    DONE_NAME_1 = 7;
    step();
    DONE_E_1 = 1'b0;
    COMMIT_E = 1'b1;
    ENQ_E = 1'b1;
    ENQ_NAME = 9;
    settle();
    chk("full_ret_fe", 32'(FE), 1);
    chk("full_ret_name", 32'(NAME_F), 7);
    chk("full_ret_no_bypass", 32'(ENQ_READY), 0);
    step();
    idle_in();
    settle();
    chk("after_ret_ready", 32'(ENQ_READY), 1);
    chk("after_ret_count", 32'(COUNT), 3);
    chk("after_ret_head", 32'(HEAD_NAME), 1);
    DONE_E_1 = 1'b1;
    DONE_NAME_1 = 1;
    DONE_E_2 = 1'b1;
    DONE_NAME_2 = 2;
    step();
    DONE_E_2 = 1'b0;
    DONE_NAME_1 = 4;
    step();
    DONE_E_1 = 1'b0;
    COMMIT_E = 1'b1;
    settle();
    chk("drain_1", 32'(NAME_F), 1);
    step();
    settle();
    chk("drain_2", 32'(NAME_F), 2);
    step();
    settle();
    chk("drain_4", 32'(NAME_F), 4);
    chk("drain_4_fe", 32'(FE), 1);
    step();
    COMMIT_E = 1'b0;
    settle();
    chk("drained_count", 32'(COUNT), 0);
    chk("drained_head", 32'(HEAD_NAME), 0);

    // writeback wins over a same-cycle enqueue
    ENQ_E = 1'b1;
    ENQ_NAME = 3;
    DONE_E_2 = 1'b1;
    DONE_NAME_2 = 3;
    step();
    idle_in();
    settle();
    chk("wb_win_ready", 32'(COMMIT_READY), 1);
    chk("wb_win_head", 32'(HEAD_NAME), 3);
    COMMIT_E = 1'b1;
    step();
    COMMIT_E = 1'b0;
    settle();
    chk("wb_win_empty", 32'(COUNT), 0);

    // sustained enqueue/retire across pointer wrap
    ENQ_E = 1'b1;
    ENQ_NAME = 1;
    DONE_E_1 = 1'b1;
    DONE_NAME_1 = 1;
    step();
    for (int k = 1; k <= 9; k++) begin
      ENQ_E = 1'b1;
      ENQ_NAME = NW'(k + 1);
      COMMIT_E = 1'b1;
      DONE_E_1 = (k % 2 == 0) || (k == 5);
      DONE_E_2 = (k % 2 == 1);
      DONE_NAME_1 = NW'(k + 1);
      DONE_NAME_2 = NW'(k + 1);
      settle();
      chk($sformatf("wrap_fe_%0d", k), 32'(FE), 1);
      chk($sformatf("wrap_name_%0d", k), 32'(NAME_F), k);
      chk($sformatf("wrap_cnt_%0d", k), 32'(COUNT), 1);
      step();
    end
    idle_in();
    COMMIT_E = 1'b1;
    settle();
    chk("wrap_name_10", 32'(NAME_F), 10);
    step();
    COMMIT_E = 1'b0;
    settle();
    chk("wrap_empty", 32'(COUNT), 0);

    // asynchronous reset with live entries
    enq(11);
    enq(12);
    ENQ_E = 1'b1;
    ENQ_NAME = 13;
    DONE_E_1 = 1'b1;
    DONE_NAME_1 = 11;
    DONE_E_2 = 1'b1;
    DONE_NAME_2 = 12;
    step();
    idle_in();
    settle();
    chk("pre_rst_count", 32'(COUNT), 3);
    chk("pre_rst_ready", 32'(COMMIT_READY), 1);
    COMMIT_E = 1'b1;
    #1;
    RST = 1'b1;
    #1;
    chk("arst_count", 32'(COUNT), 0);
    chk("arst_enq_ready", 32'(ENQ_READY), 1);
    chk("arst_commit_ready", 32'(COMMIT_READY), 0);
    chk("arst_fe", 32'(FE), 0);
    chk("arst_name_f", 32'(NAME_F), 0);
    RST = 1'b0;
    COMMIT_E = 1'b0;
    step();
    enq(2);
    settle();
    chk("post_rst_head", 32'(HEAD_NAME), 2);
    chk("post_rst_count", 32'(COUNT), 1);
    chk("post_rst_busy", 32'(COMMIT_READY), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/rename_commit_queue.md
# rename_commit_queue

In-order retirement queue that pairs with the rename register file. Every physical name the rename file hands out on its allocate port is recorded here in program order. The queue tracks writeback completion for each recorded name. It retires the oldest completed entry by driving the rename file's free port (`NAME_F`/`FE`), which frees the superseded mapping.

## Interface
- `name_width`, 1, width of a physical register name; must match the rename file instance.
- `depth`, 4, number of in-flight entries; power of two, ≥2.
- `ptr_width`, 2, log2(`depth`).

- `CLK`  in  1  clock; all state updates on the rising edge.
- `RST`  in  1  reset; asynchronous, active-high.
- `ENQ_NAME`  in  name_width  newly allocated physical name (the rename file's `NAME_OUT`).
- `ENQ_E`  in  1  enqueue strobe; asserted in the same cycle as a successful allocate.
- `ENQ_READY`  out  1  queue not full.
- `DONE_NAME_1`  in  name_width  writeback name, port 1.
- `DONE_E_1`  in  1  writeback strobe, port 1; mirrors `WE_1` on the rename file.
- `DONE_NAME_2`  in  name_width  writeback name, port 2.
- `DONE_E_2`  in  1  writeback strobe, port 2; mirrors `WE_2` on the rename file.
- `COMMIT_E`  in  1  retire request from the pipeline.
- `COMMIT_READY`  out  1  head entry is valid and done.
- `HEAD_NAME`  out  name_width  name of the head entry; 0 when empty.
- `NAME_F`  out  name_width  name to free; equals `HEAD_NAME`.
- `FE`  out  1  free strobe: `COMMIT_E && COMMIT_READY`.
- `COUNT`  out  ptr_width+1  number of valid entries.

## Operation
- State:
  - circular array of `depth` entries, each holding {name, done};
  - `head`/`tail` pointers, `ptr_width` bits, wrapping modulo `depth`;
  - `count` register, `ptr_width`+1 bits.
- Enqueue: when `ENQ_E && ENQ_READY`:
  - entry[tail] ← {ENQ_NAME, done=0};
  - tail ← tail+1.
- Enqueue while full (`ENQ_E` with `!ENQ_READY`): ignored. No state change.
- Done marking: for each port k where `DONE_E_k` is high, every valid entry whose name equals `DONE_NAME_k` sets done=1.
- Valid entry names are unique, because names stay allocated while queued. At most one entry matches per port.
- A done strobe that matches no valid entry is ignored.
- Enqueue and done in the same cycle for the same name: the new entry is written with done=1 (writeback wins, matching busy-bit priority in the rename file).
- Retire: when `FE` is high:
  - head entry invalidated;
  - head ← head+1.
- `COMMIT_E` while `!COMMIT_READY`: ignored.
- Count update: `count` ← count + enq_fire − commit_fire. Simultaneous enqueue and retire leaves `count` unchanged.
- Outputs:
  - `ENQ_READY` = (count != depth);
  - `COMMIT_READY` = (count != 0) && entry[head].done;
  - `HEAD_NAME`/`NAME_F` = entry[head].name when count != 0, else 0.

## Timing
- Reset (async, immediate): head=tail=0, count=0, all done bits 0.
  - Output values during and after reset: `ENQ_READY`=1, `COMMIT_READY`=0, `FE`=0, `HEAD_NAME`=`NAME_F`=0, `COUNT`=0.
- Reset asserted mid-operation discards all entries. Names held in the queue are not freed; the rename file is reset together with the queue.
- Enqueue-to-visibility: an entry enqueued in cycle N is counted in `COUNT` and visible at head from cycle N+1.
- Done-to-commit: a done strobe in cycle N can raise `COMMIT_READY` at cycle N+1 at the earliest. There is no same-cycle bypass from `DONE_E_k` to `COMMIT_READY`.
- `FE` is combinational from `COMMIT_E` and registered state, so the free happens in the same cycle as the commit request.
- Full queue with retire in the same cycle: `ENQ_READY` stays 0 that cycle, because it is computed from registered count only (no bypass). Enqueue is accepted from the next cycle.
- Both done ports naming the same entry in one cycle: the result is the same as one strobe.
- Throughput: one enqueue and one retire per cycle, sustained.
- Pointer wrap: depth−1 → 0. Full vs. empty is distinguished only by `count`.

## Structure
- Shared rename package/include holds `name_width` and the physical register count, so this block and the rename file are instantiated from the same constants.
- `ptr_width` is derived there as log2 of `depth`.
- Single module; the per-entry name comparator is inline. No sub-module.
- An optional natural split is `rename_cq_match` (2-port name CAM over entries, returning a match vector). Only split it out if it is reused.

## Test plan
- Reset then idle → `ENQ_READY`=1, `COMMIT_READY`=0, `FE`=0, `COUNT`=0, `NAME_F`=0.
- Enqueue names 5,6,7; `DONE_E_1` name 6; `COMMIT_E` held high → no `FE` (head 5 not done). Then done name 5 → next cycle `FE`=1 with `NAME_F`=5, following cycle `FE`=1 with `NAME_F`=6, then `COMMIT_READY`=0 (7 not done).
- Fill `depth`=4 entries → `ENQ_READY`=0. Extra `ENQ_E` with name 9 → `COUNT` stays 4, name 9 never appears. Retire one → `ENQ_READY`=1 next cycle.
- Enqueue name 3 with `DONE_E_2` name 3 in the same cycle → next cycle `COMMIT_READY`=1 and `HEAD_NAME`=3.
- Run 10 enqueue/retire pairs through `depth`=4, with done strobes on both ports → pointers wrap, `NAME_F` sequence equals enqueue order, `COUNT` never exceeds 4.
- Assert `RST` asynchronously with 3 entries, 2 of them done → outputs return to reset values before the next clock edge. Subsequent enqueue of name 2 lands at head.
